reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/cpu_pkg.sv | 73 +++++++
 rtl/reg16.sv | 40 ++++
 rtl/reg_bank.sv | 239 +++++++++++++++++++++++
 tb/tb_reg_bank.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the register bank and the control unit.
//
// Contents
//   DataWidth   - datapath width (16 bits)
//   word_t      - one datapath word
//   Bit*        - indices into the write_en / inc_en / clr_en vectors
//   rd_sel_e    - bus source codes carried on read_en
//   next_word() - clr > write > inc update rule for one register
//
// Optional feature: the macro REG_BANK_R5_EN turns on register R5
// (enable bit BitR5, read code RdR5). The constants exist in both builds
// so that the control unit can be compiled unchanged.
package cpu_pkg;

    localparam int unsigned DataWidth = 16;

    typedef logic [DataWidth-1:0] word_t;

    // Enable-vector bit indices. Bits 0 and 13..15 have no target.
    localparam int unsigned BitPc    = 1;
    localparam int unsigned BitAr    = 2;
    localparam int unsigned BitIr    = 3;
    localparam int unsigned BitAcBus = 4;   // AC loaded from the bus
    localparam int unsigned BitR     = 5;
    localparam int unsigned BitR5    = 6;   // only used with REG_BANK_R5_EN
    localparam int unsigned BitR4    = 7;
    localparam int unsigned BitR3    = 8;
    localparam int unsigned BitR2    = 9;
    localparam int unsigned BitR1    = 10;
    localparam int unsigned BitDm    = 11;  // data memory write strobe
    localparam int unsigned BitAcAlu = 12;  // AC loaded from alu_out

    // Bus source codes. Reserved codes drive an all-zero bus.
    typedef enum logic [3:0] {
        RdNone   = 4'd0,
        RdPc     = 4'd1,
        RdAr     = 4'd2,
        RdRsvd3  = 4'd3,
        RdIr     = 4'd4,
        RdAc     = 4'd5,
        RdR      = 4'd6,
        RdR1     = 4'd7,
        RdR2     = 4'd8,
        RdR3     = 4'd9,
        RdR4     = 4'd10,
        RdR5     = 4'd11,
        RdDm     = 4'd12,
        RdIm     = 4'd13,
        RdRsvd14 = 4'd14,
        RdRsvd15 = 4'd15
    } rd_sel_e;

    // Next value of a register: clear wins over write, write over increment.
    // Increment wraps modulo 2^DataWidth.
    function automatic word_t next_word(input logic  clr,
                                        input logic  we,
                                        input logic  inc,
                                        input word_t d,
                                        input word_t q);
        word_t res;
        if (clr) begin
            res = '0;
        end else if (we) begin
            res = d;
        end else if (inc) begin
            res = q + word_t'(1);
        end else begin
            res = q;
        end
        return res;
    endfunction

endpackage

// File: rtl/reg16.sv
// reg16: one datapath register with clear, load and increment.
//
// Ports
//   clk    - clock, state updates on the rising edge
//   rst_n  - asynchronous active-low reset, clears the register
//   clr_i  - load zero (highest priority)
//   we_i   - load d_i
//   inc_i  - add one, wrapping (lowest priority)
//   d_i    - load data
//   q_o    - register contents
module reg16
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 we_i,
    input  logic                 inc_i,
    input  logic [DataWidth-1:0] d_i,
    output logic [DataWidth-1:0] q_o
);

    logic [DataWidth-1:0] q_d;
    logic [DataWidth-1:0] q_q;

    always_comb begin
        q_d = next_word(clr_i, we_i, inc_i, d_i, q_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/reg_bank.sv
// reg_bank: CPU register file with a single shared data bus.
//
// A source is put on the bus with read_en (see cpu_pkg::rd_sel_e). The
// selected value is also captured in a bus latch, so a source read in one
// cycle can still be written into a register in a later cycle where
// read_en is zero. Registers load from that effective bus, except AC,
// which can also load alu_out.
//
// Ports
//   clk, rst_n                 - clock and asynchronous active-low reset
//   write_en, inc_en, clr_en   - per-target load / increment / clear enables
//   read_en                    - bus source code
//   alu_out                    - ALU result, alternate AC load source
//   im_data, dm_data           - instruction / data memory read data
//   pc, ar, ir, ac, r, r1..r4  - register contents
//   r5                         - extra register, only with REG_BANK_R5_EN
//   z                          - 1 when ac is zero, else 0 (16-bit wide)
//   im_addr, dm_addr           - memory addresses (pc, ar)
//   dm_we, dm_wdata            - data memory write strobe and data
//
// Build option: define REG_BANK_R5_EN to add register R5 (enable bit 6,
// read code 11). Without it, bit 6 is ignored and code 11 reads zero.
module reg_bank
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          write_en,
    input  logic [15:0]          inc_en,
    input  logic [15:0]          clr_en,
    input  logic [3:0]           read_en,
    input  logic [DataWidth-1:0] alu_out,
    input  logic [DataWidth-1:0] im_data,
    input  logic [DataWidth-1:0] dm_data,
    output logic [DataWidth-1:0] pc,
    output logic [DataWidth-1:0] ar,
    output logic [DataWidth-1:0] ir,
    output logic [DataWidth-1:0] ac,
    output logic [DataWidth-1:0] r,
    output logic [DataWidth-1:0] r1,
    output logic [DataWidth-1:0] r2,
    output logic [DataWidth-1:0] r3,
    output logic [DataWidth-1:0] r4,
`ifdef REG_BANK_R5_EN
    output logic [DataWidth-1:0] r5,
`endif
    output logic [DataWidth-1:0] z,
    output logic [DataWidth-1:0] im_addr,
    output logic [DataWidth-1:0] dm_addr,
    output logic                 dm_we,
    output logic [DataWidth-1:0] dm_wdata
);

    logic [DataWidth-1:0] bus_sel;   // combinational source selection
    logic [DataWidth-1:0] bus_q;     // last value driven onto the bus
    logic [DataWidth-1:0] bus_eff;   // what every bus write actually sees
    logic                 bus_drive;

    logic                 ac_clr;
    logic                 ac_we;
    logic                 ac_inc;
    logic [DataWidth-1:0] ac_d;

    // ---------------------------------------------------------------------
    // Bus source selection
    // ---------------------------------------------------------------------
    always_comb begin
        bus_sel = '0;
        unique case (read_en)
            RdPc:    bus_sel = pc;
            RdAr:    bus_sel = ar;
            RdIr:    bus_sel = ir;
            RdAc:    bus_sel = ac;
            RdR:     bus_sel = r;
            RdR1:    bus_sel = r1;
            RdR2:    bus_sel = r2;
            RdR3:    bus_sel = r3;
            RdR4:    bus_sel = r4;
`ifdef REG_BANK_R5_EN
            RdR5:    bus_sel = r5;
`endif
            RdDm:    bus_sel = dm_data;
            RdIm:    bus_sel = im_data;
            default: bus_sel = '0;
        endcase
    end

    assign bus_drive = (read_en != 4'd0);

    // The latch only follows the bus while a source is being driven.
    reg16 u_bus_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .we_i  (bus_drive),
        .inc_i (1'b0),
        .d_i   (bus_sel),
        .q_o   (bus_q)
    );

    assign bus_eff = bus_drive ? bus_sel : bus_q;

    // ---------------------------------------------------------------------
    // General registers, all loaded from the effective bus
    // ---------------------------------------------------------------------
    reg16 u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_en[BitPc]),
        .we_i  (write_en[BitPc]),
        .inc_i (inc_en[BitPc]),
        .d_i   (bus_eff),
        .q_o   (pc)
    );

    reg16 u_ar (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_en[BitAr]),
        .we_i  (write_en[BitAr]),
        .inc_i (inc_en[BitAr]),
        .d_i   (bus_eff),
        .q_o   (ar)
    );

    reg16 u_ir (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_en[BitIr]),
        .we_i  (write_en[BitIr]),
        .inc_i (inc_en[BitIr]),
        .d_i   (bus_eff),
        .q_o   (ir)
    );

    reg16 u_r (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_en[BitR]),
        .we_i  (write_en[BitR]),
        .inc_i (inc_en[BitR]),
        .d_i   (bus_eff),
        .q_o   (r)
    );

    reg16 u_r1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_en[BitR1]),
        .we_i  (write_en[BitR1]),
        .inc_i (inc_en[BitR1]),
        .d_i   (bus_eff),
        .q_o   (r1)
    );

    reg16 u_r2 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_en[BitR2]),
        .we_i  (write_en[BitR2]),
        .inc_i (inc_en[BitR2]),
        .d_i   (bus_eff),
        .q_o   (r2)
    );

    reg16 u_r3 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_en[BitR3]),
        .we_i  (write_en[BitR3]),
        .inc_i (inc_en[BitR3]),
        .d_i   (bus_eff),
        .q_o   (r3)
    );

    reg16 u_r4 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_en[BitR4]),
        .we_i  (write_en[BitR4]),
        .inc_i (inc_en[BitR4]),
        .d_i   (bus_eff),
        .q_o   (r4)
    );

`ifdef REG_BANK_R5_EN
    reg16 u_r5 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_en[BitR5]),
        .we_i  (write_en[BitR5]),
        .inc_i (inc_en[BitR5]),
        .d_i   (bus_eff),
        .q_o   (r5)
    );
`endif

    // ---------------------------------------------------------------------
    // Accumulator: two enable bits address it. alu_out beats the bus when
    // both write bits are set; a clear on either bit beats any write.
    // ---------------------------------------------------------------------
    assign ac_clr = clr_en[BitAcBus] | clr_en[BitAcAlu];
    assign ac_we  = write_en[BitAcBus] | write_en[BitAcAlu];
    assign ac_inc = inc_en[BitAcBus] | inc_en[BitAcAlu];
    assign ac_d   = write_en[BitAcAlu] ? alu_out : bus_eff;

    reg16 u_ac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (ac_clr),
        .we_i  (ac_we),
        .inc_i (ac_inc),
        .d_i   (ac_d),
        .q_o   (ac)
    );

    // ---------------------------------------------------------------------
    // Status and memory interface
    // ---------------------------------------------------------------------
    assign z        = {{(DataWidth-1){1'b0}}, (ac == '0)};
    assign im_addr  = pc;
    assign dm_addr  = ar;
    // Gated by reset so memory is never written while the bank is cleared.
    assign dm_we    = rst_n & write_en[BitDm];
    assign dm_wdata = bus_eff;

    // Enable bits with no target in this build.
    logic unused_en;
`ifdef REG_BANK_R5_EN
    assign unused_en = ^{write_en[0], write_en[15:13],
                         inc_en[0], inc_en[BitDm], inc_en[15:13],
                         clr_en[0], clr_en[BitDm], clr_en[15:13]};
`else
    assign unused_en = ^{write_en[0], write_en[BitR5], write_en[15:13],
                         inc_en[0], inc_en[BitR5], inc_en[BitDm], inc_en[15:13],
                         clr_en[0], clr_en[BitR5], clr_en[BitDm], clr_en[15:13]};
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Testbench for reg_bank (default build, R5 disabled).
module tb_reg_bank;

    logic        clk;
    logic        rst_n;
    logic [15:0] write_en, inc_en, clr_en;
    logic [3:0]  read_en;
    logic [15:0] alu_out, im_data, dm_data;
    logic [15:0] pc, ar, ir, ac, r, r1, r2, r3, r4, z;
    logic [15:0] im_addr, dm_addr, dm_wdata;
    logic        dm_we;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    reg_bank dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .write_en (write_en),
        .inc_en   (inc_en),
        .clr_en   (clr_en),
        .read_en  (read_en),
        .alu_out  (alu_out),
        .im_data  (im_data),
        .dm_data  (dm_data),
        .pc       (pc),
        .ar       (ar),
        .ir       (ir),
        .ac       (ac),
        .r        (r),
        .r1       (r1),
        .r2       (r2),
        .r3       (r3),
        .r4       (r4),
        .z        (z),
        .im_addr  (im_addr),
        .dm_addr  (dm_addr),
        .dm_we    (dm_we),
        .dm_wdata (dm_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: state held per register name, indexed by the
    // register's enable bit (AC lives at bit 4).
    // ---------------------------------------------------------------------
    logic [15:0] mr [0:15];
    logic [15:0] mbus;

    function automatic logic [15:0] msrc(input logic [3:0] code);
        case (code)
            4'd1:    return mr[1];
            4'd2:    return mr[2];
            4'd4:    return mr[3];
            4'd5:    return mr[4];
            4'd6:    return mr[5];
            4'd7:    return mr[10];
            4'd8:    return mr[9];
            4'd9:    return mr[8];
            4'd10:   return mr[7];
            4'd12:   return dm_data;
            4'd13:   return im_data;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] mbus_now();
        return (read_en != 4'd0) ? msrc(read_en) : mbus;
    endfunction

    function automatic logic [15:0] mnext(input int t);
        logic [15:0] v;
        v = mr[t];
        if (t == 4) begin
            if (clr_en[4] || clr_en[12]) v = 16'h0000;
            else if (write_en[12])       v = alu_out;
            else if (write_en[4])        v = mbus_now();
            else if (inc_en[4] || inc_en[12]) v = v + 16'd1;
        end else begin
            if (clr_en[t])        v = 16'h0000;
            else if (write_en[t]) v = mbus_now();
            else if (inc_en[t])   v = v + 16'd1;
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mr[i] <= 16'h0000;
            mbus <= 16'h0000;
        end else begin
            for (int t = 1; t <= 10; t++) begin
                if (t != 6) mr[t] <= mnext(t);
            end
            if (read_en != 4'd0) mbus <= msrc(read_en);
        end
    end

    // One compare process, every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", pc, mr[1]);
            chk("ar", ar, mr[2]);
            chk("ir", ir, mr[3]);
            chk("ac", ac, mr[4]);
            chk("r", r, mr[5]);
            chk("r1", r1, mr[10]);
            chk("r2", r2, mr[9]);
            chk("r3", r3, mr[8]);
            chk("r4", r4, mr[7]);
            chk("z", z, (mr[4] == 16'h0000) ? 16'd1 : 16'd0);
            chk("im_addr", im_addr, mr[1]);
            chk("dm_addr", dm_addr, mr[2]);
            chk("dm_we", {15'd0, dm_we}, {15'd0, rst_n & write_en[11]});
            chk("dm_wdata", dm_wdata, mbus_now());
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic set_in(input logic [15:0] w, input logic [15:0] i, input logic [15:0] c,
                          input logic [3:0] rd, input logic [15:0] alu,
                          input logic [15:0] dm, input logic [15:0] im);
        write_en = w;
        inc_en   = i;
        clr_en   = c;
        read_en  = rd;
        alu_out  = alu;
        dm_data  = dm;
        im_data  = im;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [15:0] w, input logic [15:0] i, input logic [15:0] c,
                       input logic [3:0] rd, input logic [15:0] alu,
                       input logic [15:0] dm, input logic [15:0] im);
        set_in(w, i, c, rd, alu, dm, im);
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc"}, pc, 16'h0000);
        chk({tag, "_ar"}, ar, 16'h0000);
        chk({tag, "_ir"}, ir, 16'h0000);
        chk({tag, "_ac"}, ac, 16'h0000);
        chk({tag, "_r"}, r, 16'h0000);
        chk({tag, "_r1"}, r1, 16'h0000);
        chk({tag, "_r2"}, r2, 16'h0000);
        chk({tag, "_r3"}, r3, 16'h0000);
        chk({tag, "_r4"}, r4, 16'h0000);
        chk({tag, "_z"}, z, 16'd1);
        chk({tag, "_dm_we"}, {15'd0, dm_we}, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(16'h0, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0);
        step();
        step();
        chk_all_zero("reset");
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Fetch pair: bus latched in one cycle, consumed the next.
        cyc(16'h0000, 16'h0, 16'h0, 4'd13, 16'h0, 16'h0, 16'h0013);
        cyc(16'h0008, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0, 16'hFFFF);
        chk("fetch_ir", ir, 16'h0013);
        chk("model_ir", mr[3], 16'h0013);

        // Load AC from data memory, then same-cycle move AC -> R1.
        cyc(16'h0010, 16'h0, 16'h0, 4'd12, 16'h0, 16'h00AB, 16'h0);
        chk("ac_load", ac, 16'h00AB);
        cyc(16'h0400, 16'h0, 16'h0, 4'd5, 16'h0, 16'h0, 16'h0);
        chk("move_r1", r1, 16'h00AB);
        chk("model_r1", mr[10], 16'h00AB);

        // PC wrap on increment.
        cyc(16'h0002, 16'h0, 16'h0, 4'd12, 16'h0, 16'hFFFF, 16'h0);
        chk("pc_ffff", pc, 16'hFFFF);
        cyc(16'h0000, 16'h0002, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0);
        chk("pc_wrap", pc, 16'h0000);
        chk("model_pc_wrap", mr[1], 16'h0000);

        // AC priority: clear beats both writes.
        cyc(16'h1000, 16'h0, 16'h0, 4'd0, 16'h0077, 16'h0, 16'h0);
        chk("ac_alu", ac, 16'h0077);
        cyc(16'h1010, 16'h0, 16'h0010, 4'd12, 16'h0005, 16'h0009, 16'h0);
        chk("ac_clr_prio", ac, 16'h0000);
        chk("ac_clr_z", z, 16'd1);

        // alu_out beats the bus when both AC write bits are set.
        cyc(16'h1010, 16'h0, 16'h0, 4'd12, 16'h2222, 16'h1111, 16'h0);
        chk("ac_alu_prio", ac, 16'h2222);
        chk("model_ac_alu_prio", mr[4], 16'h2222);

        // Store: AR=5, AC=0x42, latch AC on the bus, then strobe DM.
        cyc(16'h0004, 16'h0, 16'h0, 4'd12, 16'h0, 16'h0005, 16'h0);
        cyc(16'h1000, 16'h0, 16'h0, 4'd0, 16'h0042, 16'h0, 16'h0);
        cyc(16'h0000, 16'h0, 16'h0, 4'd5, 16'h0, 16'h0, 16'h0);
        set_in(16'h0800, 16'h0, 16'h0, 4'd0, 16'h0, 16'hBEEF, 16'h0);
        #1;
        chk("store_we", {15'd0, dm_we}, 16'd1);
        chk("store_addr", dm_addr, 16'h0005);
        chk("store_data", dm_wdata, 16'h0042);
        step();

        // ALU writeback of zero sets z immediately.
        cyc(16'h1000, 16'h0, 16'h0, 4'd0, 16'h0000, 16'h0, 16'h0);
        chk("wb_ac", ac, 16'h0000);
        chk("wb_z", z, 16'd1);

        // Simultaneous writes to several registers plus a PC increment.
        cyc(16'h03A0, 16'h0002, 16'h0, 4'd12, 16'h0, 16'h0F0F, 16'h0);
        chk("multi_r", r, 16'h0F0F);
        chk("multi_r4", r4, 16'h0F0F);
        chk("multi_r3", r3, 16'h0F0F);
        chk("multi_r2", r2, 16'h0F0F);
        chk("multi_pc", pc, 16'h0001);

        // Reserved read codes drive zero; bus_q follows them.
        cyc(16'h0020, 16'h0, 16'h0, 4'd11, 16'h0, 16'hAAAA, 16'hAAAA);
        chk("rd11_r", r, 16'h0000);
        cyc(16'h0400, 16'h0, 16'h0, 4'd14, 16'h0, 16'hAAAA, 16'hAAAA);
        chk("rd14_r1", r1, 16'h0000);
        cyc(16'h0200, 16'h0, 16'h0, 4'd3, 16'h0, 16'h0, 16'h0);
        chk("rd3_r2", r2, 16'h0000);

        // Ignored enable bits change nothing.
        cyc(16'hE041, 16'hE041, 16'h0, 4'd12, 16'h0, 16'hDEAD, 16'h0);
        chk("ignored_r3", r3, 16'h0F0F);

        // Register-to-register moves and clear/inc on R registers.
        cyc(16'h0004, 16'h0, 16'h0, 4'd8, 16'h0, 16'h0, 16'h0);
        cyc(16'h0000, 16'h0180, 16'h0100, 4'd0, 16'h0, 16'h0, 16'h0);
        chk("r4_inc", r4, 16'h0F10);
        chk("r3_clr", r3, 16'h0000);
        cyc(16'h0020, 16'h0020, 16'h0, 4'd10, 16'h0, 16'h0, 16'h0);
        chk("r_from_r4", r, 16'h0F10);

        // Mid-run reset between edges.
        cyc(16'h1000, 16'h0, 16'h0, 4'd0, 16'h1234, 16'h0, 16'h0);
        chk("pre_reset_ac", ac, 16'h1234);
        set_in(16'h0800, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        #1 rst_n = 1'b1;
        cyc(16'h0000, 16'h0002, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0);
        chk("post_reset_pc", pc, 16'h0001);

        set_in(16'h0, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0);
        step();
        step();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
